// File: rtl/parking_pkg.sv
// Shared types and constants for the car-park entry gate.
// State encodings, 7-segment glyphs and password compare.
package parking_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_WRONG = 3'd2,
      ST_RIGHT = 3'd3,
      ST_STOP  = 3'd4,
      ST_LOCK  = 3'd5
   } state_e;

   // Active-low segments, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [6:0] SEG_E   = 7'h06;
   localparam logic [6:0] SEG_N   = 7'h2B;
   localparam logic [6:0] SEG_G   = 7'h02;
   localparam logic [6:0] SEG_O   = 7'h40;
   localparam logic [6:0] SEG_S   = 7'h12;
   localparam logic [6:0] SEG_P   = 7'h0C;
   localparam logic [6:0] SEG_L   = 7'h47;
   localparam logic [6:0] SEG_F   = 7'h0E;
   localparam logic [6:0] SEG_U   = 7'h41;

   function automatic logic pw_match(
      input logic [31:0] entered,
      input logic [31:0] stored
   );
      return entered == stored;
   endfunction

endpackage

// File: rtl/parking_blink_gen.sv
// Free-running blink source for the status LEDs.
// blink_q toggles once every BLINK_DIV cycles.
module parking_blink_gen #(
   parameter int unsigned BLINK_DIV = 8
) (
   input  logic clk,
   input  logic reset_n,
   output logic blink_q
);

   localparam int unsigned DIV_W =
      (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_d;
   logic             blink_d;

   always_comb begin
      div_d   = div_q + DIV_W'(1);
      blink_d = blink_q;
      if (div_q == DIV_W'(BLINK_DIV - 1)) begin
         div_d   = '0;
         blink_d = ~blink_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q   <= '0;
         blink_q <= 1'b0;
      end else begin
         div_q   <= div_d;
         blink_q <= blink_d;
      end
   end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Car-park entry gate: password admission, lockout,
// tailgate stop and occupancy tracking.
module parking_gate_ctrl
   import parking_pkg::*;
#(
   parameter int unsigned     N_SPACES    = 16,
   parameter int unsigned     PW_W        = 4,
   parameter logic [PW_W-1:0] PASSWORD    = 4'h6,
   parameter int unsigned     PW_TIMEOUT  = 32,
   parameter int unsigned     MAX_TRIES   = 3,
   parameter int unsigned     LOCK_CYCLES = 64,
   parameter int unsigned     BLINK_DIV   = 8,
   localparam int unsigned    OCC_W = $clog2(N_SPACES + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             sensor_entrance,
   input  logic             sensor_exit,
   input  logic             car_leaving,
   input  logic             pw_valid,
   input  logic [PW_W-1:0]  pw_data,
   output logic             gate_open,
   output logic             green_led,
   output logic             red_led,
   output logic             lot_full,
   output logic [OCC_W-1:0] occupancy,
   output logic [2:0]       state_code,
   output logic [6:0]       hex_1,
   output logic [6:0]       hex_2
);

   localparam int unsigned CNT_MAX =
      (PW_TIMEOUT > LOCK_CYCLES) ? PW_TIMEOUT : LOCK_CYCLES;
   localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
   localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [TRY_W-1:0]   tries_q, tries_d;
   logic [OCC_W-1:0]   occ_q, occ_d;
   logic               lot_full_q, lot_full_d;
   logic               admit;
   logic               match;
   logic               blink_q;

   logic               gate_q, gate_d;
   logic               green_q, green_d;
   logic               red_q, red_d;
   logic [2:0]         code_q, code_d;
   logic [6:0]         hex1_q, hex1_d;
   logic [6:0]         hex2_q, hex2_d;

   parking_blink_gen #(
      .BLINK_DIV (BLINK_DIV)
   ) u_blink (
      .clk     (clk),
      .reset_n (reset_n),
      .blink_q (blink_q)
   );

   assign match = pw_valid &&
      pw_match(32'(pw_data), 32'(PASSWORD));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         tries_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tries_q <= tries_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tries_d = tries_q;
      admit   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sensor_entrance && !lot_full_q)
               state_d = ST_WAIT;
         end
         ST_WAIT, ST_WRONG: begin
            if (match) begin
               state_d = ST_RIGHT;
               tries_d = '0;
            end else if (pw_valid) begin
               tries_d = tries_q + TRY_W'(1);
               if (tries_d == TRY_W'(MAX_TRIES))
                  state_d = ST_LOCK;
               else
                  state_d = ST_WRONG;
            end else if (state_q == ST_WAIT &&
                         cnt_q == CNT_W'(PW_TIMEOUT - 1)) begin
               state_d = ST_IDLE;
            end
         end
         ST_LOCK: begin
            if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
               state_d = ST_IDLE;
               tries_d = '0;
            end
         end
         ST_RIGHT: begin
            if (sensor_exit) begin
               admit   = 1'b1;
               state_d = sensor_entrance ? ST_STOP : ST_IDLE;
            end
         end
         ST_STOP: begin
            if (match) begin
               state_d = ST_RIGHT;
               tries_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Shared timer: restarts on every state entry
   always_comb begin
      cnt_d = '0;
      if (state_d == state_q &&
          (state_q == ST_WAIT || state_q == ST_LOCK))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_comb begin
      occ_d = occ_q;
      if (admit && !car_leaving) begin
         if (occ_q != OCC_W'(N_SPACES))
            occ_d = occ_q + OCC_W'(1);
      end else if (!admit && car_leaving) begin
         if (occ_q != '0)
            occ_d = occ_q - OCC_W'(1);
      end
      lot_full_d = (occ_d == OCC_W'(N_SPACES));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         occ_q      <= '0;
         lot_full_q <= 1'b0;
      end else begin
         occ_q      <= occ_d;
         lot_full_q <= lot_full_d;
      end
   end

   always_comb begin
      gate_d  = 1'b0;
      green_d = 1'b0;
      red_d   = 1'b0;
      code_d  = state_q;
      hex1_d  = SEG_OFF;
      hex2_d  = SEG_OFF;
      case (state_q)
         ST_IDLE: begin
            if (lot_full_q) begin
               red_d  = 1'b1;
               hex1_d = SEG_F;
               hex2_d = SEG_U;
            end
         end
         ST_WAIT: begin
            red_d  = 1'b1;
            hex1_d = SEG_E;
            hex2_d = SEG_N;
         end
         ST_WRONG: begin
            red_d  = blink_q;
            hex1_d = SEG_E;
            hex2_d = SEG_E;
         end
         ST_RIGHT: begin
            gate_d  = 1'b1;
            green_d = blink_q;
            hex1_d  = SEG_G;
            hex2_d  = SEG_O;
         end
         ST_STOP: begin
            red_d  = blink_q;
            hex1_d = SEG_S;
            hex2_d = SEG_P;
         end
         ST_LOCK: begin
            red_d  = blink_q;
            hex1_d = SEG_L;
            hex2_d = SEG_O;
         end
         default: begin
            code_d = state_q;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gate_q  <= 1'b0;
         green_q <= 1'b0;
         red_q   <= 1'b0;
         code_q  <= 3'd0;
         hex1_q  <= SEG_OFF;
         hex2_q  <= SEG_OFF;
      end else begin
         gate_q  <= gate_d;
         green_q <= green_d;
         red_q   <= red_d;
         code_q  <= code_d;
         hex1_q  <= hex1_d;
         hex2_q  <= hex2_d;
      end
   end

   assign gate_open  = gate_q;
   assign green_led  = green_q;
   assign red_led    = red_q;
   assign lot_full   = lot_full_q;
   assign occupancy  = occ_q;
   assign state_code = code_q;
   assign hex_1      = hex1_q;
   assign hex_2      = hex2_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl: vector table
// plus hand sequences for lockout, timeout, full lot, reset.
module tb_parking_gate_ctrl;

   logic       clk;
   logic       reset_n;
   logic       sensor_entrance;
   logic       sensor_exit;
   logic       car_leaving;
   logic       pw_valid;
   logic [3:0] pw_data;
   logic       gate_open;
   logic       green_led;
   logic       red_led;
   logic       lot_full;
   logic [4:0] occupancy;
   logic [2:0] state_code;
   logic [6:0] hex_1;
   logic [6:0] hex_2;

   int n_checks = 0;
   int n_err    = 0;

   typedef struct {
      logic       e;
      logic       x;
      logic       l;
      logic       v;
      logic [3:0] d;
      logic [2:0] code;
      logic       gate;
      logic [4:0] occ;
      logic [6:0] h1;
      logic [6:0] h2;
      logic       chk_red;
      logic       red;
   } vec_t;

   vec_t vec [15];

   parking_gate_ctrl dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .sensor_entrance (sensor_entrance),
      .sensor_exit     (sensor_exit),
      .car_leaving     (car_leaving),
      .pw_valid        (pw_valid),
      .pw_data         (pw_data),
      .gate_open       (gate_open),
      .green_led       (green_led),
      .red_led         (red_led),
      .lot_full        (lot_full),
      .occupancy       (occupancy),
      .state_code      (state_code),
      .hex_1           (hex_1),
      .hex_2           (hex_2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(
      input string       nm,
      input logic [31:0] act,
      input logic [31:0] exp
   );
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
      end
   endtask

   task automatic step(
      input logic       e,
      input logic       x,
      input logic       l,
      input logic       v,
      input logic [3:0] d
   );
      sensor_entrance = e;
      sensor_exit     = x;
      car_leaving     = l;
      pw_valid        = v;
      pw_data         = d;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(
      input string      nm,
      input logic [2:0] code,
      input logic       gate,
      input logic [4:0] occ,
      input logic [6:0] h1,
      input logic [6:0] h2
   );
      chk({nm, "_code"}, 32'(state_code), 32'(code));
      chk({nm, "_gate"}, 32'(gate_open), 32'(gate));
      chk({nm, "_occ"}, 32'(occupancy), 32'(occ));
      chk({nm, "_hex"}, {18'd0, hex_1, hex_2},
          {18'd0, h1, h2});
   endtask

   task automatic admit_car();
      step(1, 0, 0, 0, 4'h0);
      step(0, 0, 0, 0, 4'h0);
      step(0, 0, 0, 1, 4'h6);
      step(0, 0, 0, 0, 4'h0);
      step(0, 1, 0, 0, 4'h0);
      step(0, 0, 0, 0, 4'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: no finish by %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      int toggles;
      int first;
      logic prev;

      vec[0]  = '{1,0,0,0,4'h0, 0,0,0,7'h7F,7'h7F,1,0};
      vec[1]  = '{0,0,0,0,4'h0, 1,0,0,7'h06,7'h2B,1,1};
      vec[2]  = '{0,0,0,1,4'h6, 1,0,0,7'h06,7'h2B,1,1};
      vec[3]  = '{0,0,0,0,4'h0, 3,1,0,7'h02,7'h40,0,0};
      vec[4]  = '{0,1,0,0,4'h0, 3,1,1,7'h02,7'h40,0,0};
      vec[5]  = '{0,0,0,0,4'h0, 0,0,1,7'h7F,7'h7F,1,0};
      vec[6]  = '{1,0,0,0,4'h0, 0,0,1,7'h7F,7'h7F,1,0};
      vec[7]  = '{0,0,0,1,4'h6, 1,0,1,7'h06,7'h2B,1,1};
      vec[8]  = '{1,1,0,0,4'h0, 3,1,2,7'h02,7'h40,0,0};
      vec[9]  = '{1,0,0,0,4'h0, 4,0,2,7'h12,7'h0C,0,0};
      vec[10] = '{0,0,0,1,4'h3, 4,0,2,7'h12,7'h0C,0,0};
      vec[11] = '{0,0,0,1,4'h6, 4,0,2,7'h12,7'h0C,0,0};
      vec[12] = '{0,0,0,0,4'h0, 3,1,2,7'h02,7'h40,0,0};
      vec[13] = '{0,1,0,0,4'h0, 3,1,3,7'h02,7'h40,0,0};
      vec[14] = '{0,0,0,0,4'h0, 0,0,3,7'h7F,7'h7F,1,0};

      reset_n         = 1'b0;
      sensor_entrance = 1'b0;
      sensor_exit     = 1'b0;
      car_leaving     = 1'b0;
      pw_valid        = 1'b0;
      pw_data         = 4'h0;
      repeat (2) @(posedge clk);
      #1;
      chk_out("rst", 0, 0, 0, 7'h7F, 7'h7F);
      chk("rst_leds", {30'd0, red_led, green_led}, 0);
      chk("rst_full", 32'(lot_full), 0);
      reset_n = 1'b1;
      step(0, 0, 0, 0, 4'h0);
      chk_out("post_rst", 0, 0, 0, 7'h7F, 7'h7F);

      // Admission, then tailgate stop
      for (int i = 0; i < 15; i++) begin
         step(vec[i].e, vec[i].x, vec[i].l,
              vec[i].v, vec[i].d);
         chk_out($sformatf("vec%0d", i), vec[i].code,
                 vec[i].gate, vec[i].occ,
                 vec[i].h1, vec[i].h2);
         if (vec[i].chk_red)
            chk($sformatf("vec%0d_red", i),
                32'(red_led), 32'(vec[i].red));
      end

      // Three wrong entries lead to lockout
      step(1, 0, 0, 0, 4'h0);
      step(0, 0, 0, 0, 4'h0);
      step(0, 0, 0, 1, 4'h3);
      step(0, 0, 0, 0, 4'h0);
      chk_out("wrong1", 2, 0, 3, 7'h06, 7'h06);
      step(0, 0, 0, 1, 4'h3);
      step(0, 0, 0, 0, 4'h0);
      chk("wrong2_code", 32'(state_code), 2);
      step(0, 0, 0, 1, 4'h3);
      step(0, 0, 0, 0, 4'h0);
      chk_out("lock", 5, 0, 3, 7'h47, 7'h40);
      bad     = 0;
      toggles = 0;
      prev    = red_led;
      for (int i = 1; i <= 64; i++) begin
         step(0, 0, 0, (i % 7 == 0) && (i < 60), 4'h6);
         if (i < 64) begin
            if (state_code != 3'd5) bad++;
            if (green_led) bad++;
            if (red_led != prev) toggles++;
            prev = red_led;
         end
      end
      chk("lock_hold", 32'(bad), 0);
      chk("lock_exit", 32'(state_code), 0);
      chk("lock_blink", 32'(toggles >= 7 && toggles <= 8), 1);

      // Password timeout
      step(1, 0, 0, 0, 4'h0);
      first = 0;
      for (int i = 1; i <= 40; i++) begin
         step(0, 0, 0, 0, 4'h0);
         if (first == 0 && state_code == 3'd0) first = i;
      end
      chk("timeout_cycles", 32'(first), 33);
      chk("timeout_occ", 32'(occupancy), 3);

      // Departure, then fill the lot
      step(0, 0, 1, 0, 4'h0);
      chk("leave_occ", 32'(occupancy), 2);
      for (int i = 0; i < 13; i++) admit_car();
      chk("fill15_occ", 32'(occupancy), 15);
      chk("fill15_full", 32'(lot_full), 0);
      step(1, 0, 0, 0, 4'h0);
      step(0, 0, 0, 0, 4'h0);
      step(0, 0, 0, 1, 4'h6);
      step(0, 0, 0, 0, 4'h0);
      step(1, 1, 0, 0, 4'h0);
      chk("fill16_occ", 32'(occupancy), 16);
      chk("fill16_full", 32'(lot_full), 1);
      step(0, 0, 0, 0, 4'h0);
      chk("full_stop", 32'(state_code), 4);
      step(0, 0, 0, 1, 4'h6);
      step(0, 0, 0, 0, 4'h0);
      step(0, 1, 1, 0, 4'h0);
      chk("net0_occ", 32'(occupancy), 16);
      step(0, 0, 0, 0, 4'h0);
      chk_out("full_idle", 0, 0, 16, 7'h0E, 7'h41);
      chk("full_red", 32'(red_led), 1);
      step(1, 0, 0, 0, 4'h0);
      step(1, 0, 0, 0, 4'h0);
      step(1, 0, 0, 0, 4'h0);
      chk("full_refuse", 32'(state_code), 0);
      step(0, 0, 1, 0, 4'h0);
      chk("unfull_occ", 32'(occupancy), 15);
      chk("unfull_full", 32'(lot_full), 0);
      step(0, 0, 0, 0, 4'h0);
      chk("unfull_hex", {18'd0, hex_1, hex_2},
          {18'd0, 7'h7F, 7'h7F});

      // Asynchronous reset in the middle of admission
      step(1, 0, 0, 0, 4'h0);
      step(0, 0, 0, 0, 4'h0);
      step(0, 0, 0, 1, 4'h6);
      step(0, 0, 0, 0, 4'h0);
      chk_out("pre_rst", 3, 1, 15, 7'h02, 7'h40);
      #2;
      reset_n = 1'b0;
      #1;
      chk_out("mid_rst", 0, 0, 0, 7'h7F, 7'h7F);
      chk("mid_rst_leds", {30'd0, red_led, green_led}, 0);
      chk("mid_rst_full", 32'(lot_full), 0);
      step(0, 0, 0, 0, 4'h0);
      reset_n = 1'b1;
      step(0, 0, 1, 0, 4'h0);
      chk("sat0_occ", 32'(occupancy), 0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_err);
      $finish;
   end

endmodule
